// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port access sequencer and arbiter in front of a single-port Memory with a tristate data bus.
// Optional feature macro: MEMORY_ARBITER_ROUND_ROBIN_EN (round-robin on ties); default is fixed priority to port 1.
module memory_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     request0,
  input  logic                     request1,
  input  logic                     write0,
  input  logic                     write1,
  input  logic [ADDRESS_WIDTH-1:0] address0,
  input  logic [ADDRESS_WIDTH-1:0] address1,
  input  logic [DATA_WIDTH-1:0]    writeData0,
  input  logic [DATA_WIDTH-1:0]    writeData1,
  output logic                     grant0,
  output logic                     grant1,
  output logic                     done0,
  output logic                     done1,
  output logic [DATA_WIDTH-1:0]    readData,
  output logic [ADDRESS_WIDTH-1:0] memAddress,
  inout  wire  [DATA_WIDTH-1:0]    memData,
  output logic                     memReadRequest
);

  localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic                       r_port;
  logic                       r_write;
  logic [ADDRESS_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [CNT_W-1:0]           r_counter;
  logic                       r_last_grant;
  logic [DATA_WIDTH-1:0]      r_read_data;
  logic                       r_grant0, r_grant1, r_done0, r_done1;
  logic                       r_read_req, r_drive;

  logic                       w_start;
  logic                       w_tie_win;
  logic                       w_win;
  logic                       w_win_write;
  logic [ADDRESS_WIDTH-1:0]   w_win_addr;
  logic [DATA_WIDTH-1:0]      w_win_data;
  logic                       w_next_port;
  logic                       w_next_write;
  logic                       w_next_grant0, w_next_grant1, w_next_done0, w_next_done1;
  logic                       w_next_read_req, w_next_drive;

  // Arbitration; lastGrant only matters for tie-breaking in round-robin builds
  always_comb begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    w_tie_win = ~r_last_grant;
`else
    w_tie_win = 1'b1 | r_last_grant;
`endif
    w_win       = (request0 && request1) ? w_tie_win : request1;
    w_start     = (r_state == S_IDLE) && (request0 || request1);
    w_win_write = w_win ? write1     : write0;
    w_win_addr  = w_win ? address1   : address0;
    w_win_data  = w_win ? writeData1 : writeData0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (request0 || request1) w_next_state = S_ACCESS;
      S_ACCESS: if (r_counter == '0)      w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, registered below alongside the state
  always_comb begin
    w_next_port     = w_start ? w_win       : r_port;
    w_next_write    = w_start ? w_win_write : r_write;
    w_next_grant0   = 1'b0;
    w_next_grant1   = 1'b0;
    w_next_done0    = 1'b0;
    w_next_done1    = 1'b0;
    w_next_read_req = 1'b1;
    w_next_drive    = 1'b0;
    case (w_next_state)
      S_ACCESS: begin
        w_next_grant0   = ~w_next_port;
        w_next_grant1   = w_next_port;
        w_next_read_req = ~w_next_write;
        w_next_drive    = w_next_write;
      end
      S_DONE: begin
        w_next_grant0 = ~w_next_port;
        w_next_grant1 = w_next_port;
        w_next_done0  = ~w_next_port;
        w_next_done1  = w_next_port;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_port       <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_counter    <= '0;
      r_last_grant <= 1'b1;
      r_read_data  <= '0;
      r_grant0     <= 1'b0;
      r_grant1     <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_read_req   <= 1'b1;
      r_drive      <= 1'b0;
    end else begin
      if (w_start) begin
        r_port       <= w_win;
        r_write      <= w_win_write;
        r_addr       <= w_win_addr;
        r_wdata      <= w_win_data;
        r_counter    <= CNT_LOAD;
        r_last_grant <= w_win;
      end else if (r_state == S_ACCESS) begin
        if (r_counter == '0) begin
          if (!r_write) r_read_data <= memData;
        end else begin
          r_counter <= r_counter - CNT_W'(1);
        end
      end
      r_grant0   <= w_next_grant0;
      r_grant1   <= w_next_grant1;
      r_done0    <= w_next_done0;
      r_done1    <= w_next_done1;
      r_read_req <= w_next_read_req;
      r_drive    <= w_next_drive;
    end
  end

  assign memData        = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
  assign memAddress     = r_addr;
  assign memReadRequest = r_read_req;
  assign readData       = r_read_data;
  assign grant0         = r_grant0;
  assign grant1         = r_grant1;
  assign done0          = r_done0;
  assign done1          = r_done1;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized checks of memory_arbiter against a transaction-level model.
module tb_memory_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned AC = 2;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          request0, request1, write0, write1;
  logic [AW-1:0] address0, address1;
  logic [DW-1:0] writeData0, writeData1;
  logic          grant0, grant1, done0, done1, memReadRequest;
  logic [DW-1:0] readData;
  logic [AW-1:0] memAddress;
  wire  [DW-1:0] memData;

  always #5 clock = ~clock;

  memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(AC)) dut (
    .clock(clock), .reset(reset),
    .request0(request0), .request1(request1), .write0(write0), .write1(write1),
    .address0(address0), .address1(address1), .writeData0(writeData0), .writeData1(writeData1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1), .readData(readData),
    .memAddress(memAddress), .memData(memData), .memReadRequest(memReadRequest)
  );

  // Memory block stand-in: drives the bus on reads while owned, writes whenever readRequest is low
  logic [7:0] mem [256];
  assign memData = (memReadRequest && (grant0 || grant1)) ? mem[memAddress[7:0]] : 'z;
  always @(posedge clock) if (!memReadRequest) mem[memAddress[7:0]] <= memData;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: one access at a time, timed by edge offsets from its start
  int         m_n, m_s;
  bit         m_busy, m_port, m_write, m_last;
  logic [15:0] m_addr;
  logic [7:0]  m_data, m_rd;
  logic [7:0]  m_mem [256];
  int          done_q[$];

  task automatic model_reset();
    m_busy = 1'b0;
    m_rd   = 8'h00;
    m_last = 1'b1;
  endtask

  function automatic bit m_done(input int p);
    return m_busy && (m_n - m_s == int'(AC)) && (int'(m_port) == p);
  endfunction

  task automatic model_edge();
    int off;
    bit win;
    if (!reset) return;
    m_n++;
    if (m_busy) begin
      off = m_n - m_s;
      if (off == 1 && m_write) m_mem[m_addr[7:0]] = m_data;
      if (off == int'(AC) && !m_write) m_rd = m_mem[m_addr[7:0]];
      if (off == int'(AC) + 1) m_busy = 1'b0;
    end else if (request0 || request1) begin
      if (request0 && request1) win = RR ? !m_last : 1'b1;
      else                      win = request1;
      m_busy  = 1'b1;
      m_s     = m_n;
      m_port  = win;
      m_write = win ? write1 : write0;
      m_addr  = win ? address1 : address0;
      m_data  = win ? writeData1 : writeData0;
      m_last  = win;
    end
  endtask

  task automatic check_outputs();
    int off;
    bit acc;
    bit dn;
    off = m_n - m_s;
    acc = m_busy && off < int'(AC);
    dn  = m_busy && off == int'(AC);
    check_val("grant0",   32'(grant0),   32'(m_busy && !m_port));
    check_val("grant1",   32'(grant1),   32'(m_busy && m_port));
    check_val("done0",    32'(done0),    32'(dn && !m_port));
    check_val("done1",    32'(done1),    32'(dn && m_port));
    check_val("read_req", 32'(memReadRequest), 32'(!(acc && m_write)));
    check_val("readData", 32'(readData), 32'(m_rd));
    if (acc) check_val("memAddress", 32'(memAddress), 32'(m_addr));
    if (acc && m_write) check_val("memData", 32'(memData), 32'(m_data));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
    if (done1) done_q.push_back(m_n);
  endtask

  task automatic wait_done(input int p);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      if (m_done(p)) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done port %0d: no completion within 40 cycles", p);
    end
  endtask

  task automatic set_req(input int p, input bit r, input bit w, input logic [15:0] a, input logic [7:0] d);
    if (p == 0) begin request0 = r; write0 = w; address0 = a; writeData0 = d; end
    else        begin request1 = r; write1 = w; address1 = a; writeData1 = d; end
  endtask

  initial begin
    bit pend [2];
    int first;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'(i) ^ 8'h5A;
      m_mem[i] = 8'(i) ^ 8'h5A;
    end
    m_n = 0;
    m_s = 0;
    set_req(0, 0, 0, 16'h0, 8'h0);
    set_req(1, 0, 0, 16'h0, 8'h0);
    reset = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clock);
    check_outputs();
    check_val("rst_memAddress", 32'(memAddress), 32'h0);
    @(negedge clock) reset = 1'b1;
    cycle();

    // Port 1 write then read back
    set_req(1, 1, 1, 16'h0000, 8'hAB);
    wait_done(1);
    set_req(1, 1, 0, 16'h0000, 8'h00);
    wait_done(1);
    check_val("p1_rd_AB", 32'(readData), 32'hAB);
    set_req(1, 0, 0, 16'h0, 8'h0);
    cycle();

    // Port 0 write then read back
    set_req(0, 1, 1, 16'h0001, 8'hCD);
    wait_done(0);
    set_req(0, 1, 0, 16'h0001, 8'h00);
    wait_done(0);
    check_val("p0_rd_CD", 32'(readData), 32'hCD);
    set_req(0, 0, 0, 16'h0, 8'h0);
    cycle();

    // Simultaneous requests straight out of reset
    @(negedge clock) reset = 1'b0;
    model_reset();
    #1 check_val("rst2_readData", 32'(readData), 32'h0);
    @(negedge clock) reset = 1'b1;
    cycle();
    set_req(0, 1, 0, 16'h0001, 8'h00);
    set_req(1, 1, 0, 16'h0000, 8'h00);
    cycle();
    check_val("tie_grant0", 32'(grant0), 32'(RR));
    check_val("tie_grant1", 32'(grant1), 32'(!RR));
    first = RR ? 0 : 1;
    wait_done(first);
    set_req(first, 0, 0, 16'h0, 8'h0);
    wait_done(1 - first);
    set_req(1 - first, 0, 0, 16'h0, 8'h0);
    cycle();

    // Reset during a write access: bus released at once, no completion, memory untouched
    set_req(1, 1, 1, 16'h0002, 8'h77);
    cycle();
    check_val("mw_write_active", 32'(memReadRequest), 32'h0);
    reset = 1'b0;
    model_reset();
    #1;
    check_val("mw_grant1", 32'(grant1), 32'h0);
    check_val("mw_read_req", 32'(memReadRequest), 32'h1);
    check_val("mw_done1", 32'(done1), 32'h0);
    set_req(1, 0, 0, 16'h0, 8'h0);
    cycle();
    cycle();
    @(negedge clock) reset = 1'b1;
    cycle();
    set_req(1, 1, 0, 16'h0002, 8'h00);
    wait_done(1);
    check_val("mw_rd_old", 32'(readData), 32'h58);
    set_req(1, 0, 0, 16'h0, 8'h0);
    cycle();

    // Back-to-back reads with the request held
    done_q.delete();
    for (int a = 0; a < 3; a++) begin
      set_req(1, 1, 0, 16'(a), 8'h00);
      wait_done(1);
    end
    set_req(1, 0, 0, 16'h0, 8'h0);
    cycle();
    check_val("b2b_count", 32'(done_q.size()), 32'd3);
    if (done_q.size() == 3) begin
      check_val("b2b_gap0", 32'(done_q[1] - done_q[0]), 32'(AC + 2));
      check_val("b2b_gap1", 32'(done_q[2] - done_q[1]), 32'(AC + 2));
    end

    // Randomized traffic on both ports
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (m_done(p)) pend[p] = 1'b0;
        if (!pend[p]) begin
          if ($urandom_range(0, 1) == 1) begin
            set_req(p, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 8'($urandom));
            pend[p] = 1'b1;
          end else begin
            set_req(p, 1'b0, 1'b0, 16'h0, 8'h0);
          end
        end
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequencer and arbiter for the single-port `Memory` block, which has a 16-bit address, an 8-bit bidirectional data bus and a `readRequest` strobe. It shares the memory between two requesters: port 0 is instruction fetch and port 1 is data load/store. It owns the tristate data bus, drives the memory's `readRequest` and holds each access for a fixed number of cycles. It sits between the CPU front end / execute stage and `Memory`.

## Interface
- `ADDRESS_WIDTH`, 16: width of all address ports.
- `DATA_WIDTH`, 8: width of all data ports and of the memory bus.
- `ACCESS_CYCLES`, 2: cycles each access is held on the memory (≥1).
- `clock` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `request0`, `request1` in 1: access request from port 0 / port 1.
- `write0`, `write1` in 1: 1 = write, 0 = read.
- `address0`, `address1` in ADDRESS_WIDTH: access address.
- `writeData0`, `writeData1` in DATA_WIDTH: write data.
- `grant0`, `grant1` out 1: port currently owns the memory.
- `done0`, `done1` out 1: one-cycle completion pulse.
- `readData` out DATA_WIDTH: last read result, shared by both ports, valid from `done` onward.
- `memAddress` out ADDRESS_WIDTH: to `Memory.address`.
- `memData` inout DATA_WIDTH: to `Memory.data`.
- `memReadRequest` out 1: to `Memory.readRequest`.

## Operation
- The memory writes on every edge where `readRequest`=0. For that reason `memReadRequest` is 1 in every state except a write ACCESS.
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE**
  - `memData` is high-Z.
  - On an edge where any request is high, the arbiter latches the winner's address, write flag and writeData, loads `counter`=ACCESS_CYCLES-1 and moves to ACCESS.
- **ACCESS**
  - `memAddress` = latched address and `memReadRequest` = !write.
  - For a write, `memData` = latched data; for a read, `memData` is high-Z.
  - On an edge with `counter`=0: for a read, `readData` is loaded from `memData`; the FSM then moves to DONE. Otherwise `counter` decrements.
- **DONE**
  - `done` of the granted port is 1, `memReadRequest`=1 and `memData` is high-Z.
  - The next edge moves the FSM to IDLE unconditionally.
- `grant` of the owning port is high in ACCESS and DONE; both grants are 0 in IDLE.
- **Handshake**
  - The requester holds request, write, address and writeData stable until it sees `done`.
  - On the edge where `done` is high, the requester drops the request or presents a new one.
  - Request inputs are ignored outside IDLE.
- **Arbitration**
  - Only one port is granted at a time.
  - Arbitration happens only in IDLE.
  - The `lastGrant` register records the port that won most recently.
- **Reset** (asynchronous, at any time, including mid-access)
  - State → IDLE and `memReadRequest`=1.
  - `memData` goes high-Z immediately.
  - `memAddress`=0, `readData`=0, grants=0, dones=0, `lastGrant`=1.
  - Any pending transaction is discarded and never signals `done`.
- **Address**: passed through unmodified; there is no increment and no wrap.

## Timing
- Request high at edge E (FSM in IDLE): ACCESS occupies cycles E+1 … E+ACCESS_CYCLES; `done` is high in cycle E+ACCESS_CYCLES+1.
- Latency is ACCESS_CYCLES+1 cycles from request to `done`; the throughput limit is one access per ACCESS_CYCLES+2 cycles.
- Bus turnaround: the arbiter never drives `memData` in the cycle before or after a read ACCESS, because DONE and IDLE both release the bus.
- `readData` is registered and holds its value until the next read completes.

## Configuration
- `MEMORY_ARBITER_ROUND_ROBIN_EN` defined:
  - When both requests are high in IDLE, the port ≠ `lastGrant` wins.
  - When only one request is high, that port wins.
- Not defined:
  - Fixed priority: port 1 always wins over port 0.
  - `lastGrant` is still maintained but ignored.
  - Port 0 can starve.

## Test plan
- **Reset**: hold `reset`=0 → `memReadRequest`=1, `memData`=Z, grants/dones=0, `readData`=0.
- **Port 1 write then read**, ACCESS_CYCLES=2:
  - Port 1 writes 8'hAB to 16'h0000 → `memReadRequest`=0 for 2 cycles, `done1` at request+3.
  - Port 1 then reads 16'h0000 → `readData`=8'hAB when `done1` is high.
- **Port 0 read**: port 0 writes 8'hCD to 16'h0001, then reads it back → `grant0` and `done0` asserted, `readData`=8'hCD, `grant1` stays 0.
- **Simultaneous requests from reset**:
  - With round-robin: port 0 is served first, then port 1.
  - Without the macro: port 1 first, and port 0 is served only after port 1 drops its request.
- **Mid-write reset**: assert `reset` during write ACCESS to 16'h0002 → `memData` goes Z the same cycle, no `done`; FSM is IDLE after release.
- **Back-to-back reads**: port 1 holds request through 3 consecutive reads of 16'h0000–16'h0002 → `done1` pulses spaced exactly ACCESS_CYCLES+2 cycles apart.
